// File: rtl/rggen_rtl_pkg.sv
// Shared register-bus types for the rggen bridge family.
//   rggen_access : request direction driven toward the register block
//   rggen_status : response status returned by the register block
//   is_error     : true for the two status codes reported as a bus error
package rggen_rtl_pkg;

   typedef enum logic {
      RGGEN_READ  = 1'b0,
      RGGEN_WRITE = 1'b1
   } rggen_access;

   typedef enum logic [1:0] {
      RGGEN_OKAY         = 2'b00,
      RGGEN_EXOKAY       = 2'b01,
      RGGEN_SLAVE_ERROR  = 2'b10,
      RGGEN_DECODE_ERROR = 2'b11
   } rggen_status;

   function automatic logic is_error(input rggen_status status);
      return (status == RGGEN_SLAVE_ERROR) || (status == RGGEN_DECODE_ERROR);
   endfunction

endpackage

// File: rtl/rggen_apb_bridge.sv
// APB slave to rggen register-bus bridge.
// An APB setup seen in IDLE is captured and presented as a register request;
// the register response is returned on the APB side for exactly one cycle.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_psel .. i_pstrb          APB request inputs (i_penable is not used for sequencing)
//   o_pready, o_prdata,
//   o_pslverr                  APB response, valid in the RESPONSE cycle only
//   o_request_*                register request, valid while o_request_valid=1
//   i_request_ready,
//   i_response_*               register handshake and response
module rggen_apb_bridge
   import rggen_rtl_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 16,
   parameter int BUS_WIDTH     = 32
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_psel,
   input  logic                     i_penable,
   input  logic [ADDRESS_WIDTH-1:0] i_paddr,
   input  logic                     i_pwrite,
   input  logic [BUS_WIDTH-1:0]     i_pwdata,
   input  logic [BUS_WIDTH/8-1:0]   i_pstrb,
   output logic                     o_pready,
   output logic [BUS_WIDTH-1:0]     o_prdata,
   output logic                     o_pslverr,
   output logic                     o_request_valid,
   output rggen_access              o_request_access,
   output logic [ADDRESS_WIDTH-1:0] o_request_address,
   output logic [BUS_WIDTH-1:0]     o_request_write_data,
   output logic [BUS_WIDTH-1:0]     o_request_mask,
   input  logic                     i_request_ready,
   input  rggen_status              i_response_status,
   input  logic [BUS_WIDTH-1:0]     i_response_read_data
);

   localparam int unsigned STRB_WIDTH = BUS_WIDTH / 8;
   localparam int unsigned ADDR_LSB   = $clog2(STRB_WIDTH);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      REQUEST  = 2'd1,
      RESPONSE = 2'd2
   } state_e;

   state_e                   state_q;
   state_e                   state_d;
   logic                     setup;
   logic                     complete;
   logic [BUS_WIDTH-1:0]     strb_mask;
   logic [ADDRESS_WIDTH-1:0] aligned_addr;
   logic                     unused_inputs;

   // Sequencing relies on psel alone; penable and the sub-word address bits carry no information here.
   assign unused_inputs = ^{i_penable, i_paddr[ADDR_LSB-1:0]};

   assign setup        = (state_q == IDLE) && i_psel;
   assign complete     = (state_q == REQUEST) && i_request_ready;
   assign aligned_addr = {i_paddr[ADDRESS_WIDTH-1:ADDR_LSB], ADDR_LSB'(0)};

   // Expand each byte strobe over its byte lane.
   always_comb begin
      strb_mask = '0;
      for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
         strb_mask[8*i +: 8] = {8{i_pstrb[i]}};
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; psel dropping during REQUEST does not abort the request.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (i_psel)          state_d = REQUEST;
         REQUEST:  if (i_request_ready) state_d = RESPONSE;
         RESPONSE:                      state_d = IDLE;
         default:                       state_d = IDLE;
      endcase
   end

   // Request side: fields captured at setup and held until the next setup.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_request_valid      <= 1'b0;
         o_request_access     <= RGGEN_READ;
         o_request_address    <= '0;
         o_request_write_data <= '0;
         o_request_mask       <= '0;
      end else if (setup) begin
         o_request_valid      <= 1'b1;
         o_request_access     <= i_pwrite ? RGGEN_WRITE : RGGEN_READ;
         o_request_address    <= aligned_addr;
         o_request_write_data <= i_pwrite ? i_pwdata : '0;
         o_request_mask       <= i_pwrite ? strb_mask : '1;
      end else if (complete) begin
         o_request_valid      <= 1'b0;
      end
   end

   // APB response: loaded on the ready cycle, cleared one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_pready  <= 1'b0;
         o_pslverr <= 1'b0;
         o_prdata  <= '0;
      end else begin
         o_pready  <= complete;
         o_pslverr <= complete && is_error(i_response_status);
         o_prdata  <= (complete && (o_request_access == RGGEN_READ) && !is_error(i_response_status))
                      ? i_response_read_data : '0;
      end
   end

endmodule

// File: doc/rggen_apb_bridge.md
RGGEN_APB_BRIDGE -- requirements
Module: rggen_apb_bridge

Interface
REQ-001 The block SHALL have parameter ADDRESS_WIDTH, default 16, APB/register address width in bits.
REQ-002 The block SHALL have parameter BUS_WIDTH, default 32, data width in bits; legal values 32, 64.
REQ-003 The block SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have APB inputs i_psel 1, i_penable 1, i_paddr ADDRESS_WIDTH, i_pwrite 1, i_pwdata BUS_WIDTH, i_pstrb BUS_WIDTH/8.
REQ-006 The block SHALL have APB outputs o_pready 1, o_prdata BUS_WIDTH, o_pslverr 1.
REQ-007 The block SHALL have register-side outputs o_request_valid 1, o_request_access (rggen_access), o_request_address ADDRESS_WIDTH, o_request_write_data BUS_WIDTH, o_request_mask BUS_WIDTH.
REQ-008 The block SHALL have register-side inputs i_request_ready 1, i_response_status (rggen_status), i_response_read_data BUS_WIDTH.

Function
REQ-009 The block SHALL implement FSM states IDLE, REQUEST, RESPONSE; all outputs driven from flops.
REQ-010 In IDLE with i_psel=1, the block SHALL capture paddr, pwrite, pwdata, pstrb and go to REQUEST next cycle; otherwise it stays in IDLE.
REQ-011 In REQUEST, the block SHALL assert o_request_valid with captured fields held stable until the cycle i_request_ready=1.
REQ-012 On the REQUEST cycle with i_request_ready=1, the block SHALL capture status and read data and go to RESPONSE.
REQ-013 In RESPONSE, the block SHALL assert o_pready=1 for exactly one cycle and then return to IDLE.
REQ-014 Minimum transfer SHALL be 3 cycles (setup, REQUEST with ready, RESPONSE); each extra cycle of ready low adds one APB wait state.
REQ-015 o_request_access SHALL be RGGEN_WRITE when captured pwrite=1, else RGGEN_READ.
REQ-016 o_request_address SHALL be captured paddr with the low log2(BUS_WIDTH/8) bits forced to 0.
REQ-017 o_request_mask SHALL be, for writes, each pstrb bit replicated over its byte; for reads, all ones.
REQ-018 o_request_write_data SHALL be captured pwdata for writes and 0 for reads.
REQ-019 o_pslverr SHALL be 1 in RESPONSE when captured status is RGGEN_SLAVE_ERROR or RGGEN_DECODE_ERROR, else 0; o_pslverr SHALL be 0 outside RESPONSE.
REQ-020 o_prdata SHALL be captured read data in RESPONSE for an OKAY read; it SHALL be 0 for writes, errored reads, and outside RESPONSE.
REQ-021 If i_psel drops during REQUEST (protocol violation), the block SHALL still complete the register request and pulse o_pready.
REQ-022 The block SHALL ignore i_penable for sequencing; a new setup seen in IDLE directly after RESPONSE SHALL start the next transfer without idle gap.
REQ-023 When not in REQUEST, o_request_valid SHALL be 0 and other request outputs SHALL hold last value.

Reset
REQ-024 On rst_n low, the block SHALL enter IDLE immediately, regardless of the current state.
REQ-025 Reset values SHALL be: o_request_valid 0, o_pready 0, o_pslverr 0, o_prdata 0, o_request_address 0, o_request_write_data 0, o_request_mask 0, o_request_access RGGEN_READ.
REQ-026 An in-flight request aborted by reset SHALL NOT produce o_pready after reset release.

Structure
REQ-027 Enums rggen_access (RGGEN_READ, RGGEN_WRITE) and rggen_status (RGGEN_OKAY, RGGEN_EXOKAY, RGGEN_SLAVE_ERROR, RGGEN_DECODE_ERROR) SHALL live in rggen_rtl_pkg.
REQ-028 The FSM state enum SHALL be local to the module.
REQ-029 The block SHALL be a single module with no sub-module.

Verification
REQ-030 Write 0x1234_5678 to paddr 0x0013 with pstrb 0b0101, ready on first REQUEST cycle -> o_request_address 0x0010, mask 0x00FF_00FF, pready in cycle 3, pslverr 0.
REQ-031 Read paddr 0x0020, ready low for 4 cycles, read data 0xDEAD_BEEF OKAY -> o_request_valid high for 5 cycles, o_prdata 0xDEAD_BEEF with pready, 7-cycle transfer.
REQ-032 Read answered with RGGEN_DECODE_ERROR and read data 0xFFFF_FFFF -> pslverr 1, o_prdata 0.
REQ-033 Back-to-back write then read with psel re-asserted the cycle after pready -> second request valid 2 cycles after first pready, no lost transfer.
REQ-034 rst_n pulsed low during REQUEST -> o_request_valid 0 immediately, no o_pready ever for that transfer, all outputs at reset values.
